// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, immediate-extender mode encodings and the
// opcode-to-extend-mode mapping used by the fetch/decode boundary.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [1:0] EXT_ZERO   = 2'b11;
    localparam logic [1:0] EXT_BRANCH = 2'b01;
    localparam logic [1:0] EXT_SIGN   = 2'b00;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Logical immediates and LUI zero-extend; branches need the shifted offset.
    function automatic logic [1:0] ext_sel_of(input logic [5:0] opcode);
        logic [1:0] sel;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: sel = EXT_ZERO;
            OP_BEQ, OP_BNE:                   sel = EXT_BRANCH;
            default:                          sel = EXT_SIGN;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/instr_skid_buf.sv
// Two-entry valid/ready FIFO with synchronous flush. in_ready is registered
// from the next-state occupancy; an empty FIFO presents all-zero data.
module instr_skid_buf #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         r_in_ready;

    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_next_count;

    assign out_valid = (r_count != 2'd0);
    assign in_ready  = r_in_ready;
    assign w_push    = in_valid && r_in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

    always_comb begin
        w_next_count = r_count;
        if (flush) begin
            w_next_count = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_next_count = r_count + 2'd1;
                2'b01:   w_next_count = r_count - 2'd1;
                default: w_next_count = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_count    <= w_next_count;
            r_in_ready <= (w_next_count != FULL_CNT);
            if (flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= in_data;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: skid-buffered {pc, instr} with field split and
// extender mode select. Optional stall counter under IF_ID_STALL_CNT_EN.
module if_id_stage
    import cpu_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_funct,
    output logic [15:0]     out_imm16,
    output logic [1:0]      out_ext_sel
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    logic [PC_W+31:0] w_in_data;
    logic [PC_W+31:0] w_head;

    assign w_in_data = {in_pc, in_instr};

    instr_skid_buf #(
        .W     (PC_W + 32),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_head)
    );

    // An empty buffer yields zero data, so the fields decode to NOP_INSTR.
    assign out_pc      = w_head[PC_W+31:32];
    assign out_instr   = w_head[31:0];
    assign out_opcode  = out_instr[31:26];
    assign out_rs      = out_instr[25:21];
    assign out_rt      = out_instr[20:16];
    assign out_rd      = out_instr[15:11];
    assign out_shamt   = out_instr[10:6];
    assign out_funct   = out_instr[5:0];
    assign out_imm16   = out_instr[15:0];
    assign out_ext_sel = ext_sel_of(out_opcode);

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating; only reset clears it so stalls across a flush are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline register between instruction fetch and decode.
- Buffers fetched {pc, instr} pairs in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Splits the head instruction into fields, including imm16 and the 2-bit extend-mode select consumed by the immediate extender.
- Supports a branch/jump flush.

Parameters:
- PC_W, 32, program-counter width.
- DEPTH, 2, FIFO entries (fixed at 2; other values are not supported).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; registered.
- in_pc  input  PC_W  PC of fetched instruction.
- in_instr  input  32  fetched instruction word.
- flush  input  1  discard all buffered and incoming instructions.
- out_valid  output  1  head entry valid toward decode.
- out_ready  input  1  decode consumes head this cycle.
- out_pc  output  PC_W  PC of head entry.
- out_instr  output  32  raw head instruction.
- out_opcode  output  6  instr[31:26].
- out_rs  output  5  instr[25:21].
- out_rt  output  5  instr[20:16].
- out_rd  output  5  instr[15:11].
- out_shamt  output  5  instr[10:6].
- out_funct  output  6  instr[5:0].
- out_imm16  output  16  instr[15:0], sent to the extender's data input.
- out_ext_sel  output  2  extender mode: 2'b11 = zero-extend; 2'b01 = branch offset; 2'b00 = default sign.

Behaviour:
- Reset (async, rst_n=0):
  - count=0, rd/wr pointers=0, storage cleared to 0.
  - out_valid=0, in_ready=1.
  - All field outputs and out_pc are 0; out_ext_sel=2'b00.
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready && !flush.
- Latency: an instruction pushed in cycle N is visible on out_* in cycle N+1 if the FIFO was empty, otherwise after the older entries drain.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Full (count=2): in_ready=0 in the cycle after count reaches 2. in_ready is computed from next-state count (next_count != 2) and registered. A pop while full reasserts in_ready on the next cycle.
- Empty (count=0):
  - out_valid=0.
  - Field outputs present an all-zero NOP (sll $0,$0,0), out_pc=0, out_ext_sel=2'b00.
  - No pop occurs.
- Flush:
  - Synchronous; highest priority.
  - Next cycle: count=0, pointers reset, out_valid=0, in_ready=1.
  - An instruction offered in the flush cycle is dropped.
  - out_ready in the flush cycle is ignored.
- Pointers are 1-bit and wrap 1->0.
- Field outputs decode combinationally from the head entry. No added latency.
- out_ext_sel by opcode:
  - 0x0C ANDI, 0x0D ORI, 0x0E XORI, 0x0F LUI -> 2'b11.
  - 0x04 BEQ, 0x05 BNE -> 2'b01.
  - All others -> 2'b00.
- Outputs hold stable while out_valid && !out_ready.
- Reset asserted mid-transfer discards all contents immediately.

Optional Feature:
- Macro: IF_ID_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[15:0].
  - Increments in each cycle with out_valid && !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode localparams: OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_ANDI=6'h0C, OP_ORI=6'h0D, OP_XORI=6'h0E, OP_LUI=6'h0F.
  - Extend-select encodings: EXT_ZERO=2'b11, EXT_BRANCH=2'b01, EXT_SIGN=2'b00.
  - NOP_INSTR=32'h0.
- Sub-module instr_skid_buf:
  - Generic 2-entry valid/ready FIFO of width PC_W+32 with flush.
  - if_id_stage wraps it with field decode and ext_sel logic.

Test Plan:
- Reset, then push pc=0x00400000 instr=0x3C081234 (LUI) with out_ready=1 -> next cycle: out_valid=1, out_opcode=0x0F, out_rt=8, out_imm16=0x1234, out_ext_sel=2'b11.
- Push BEQ 0x1109FFFE then ADDI 0x2129FFFF with out_ready=0:
  - After 2 pushes, in_ready=0.
  - Head shows out_ext_sel=2'b01, out_imm16=0xFFFE.
  - Raise out_ready for 1 cycle -> head becomes ADDI, out_ext_sel=2'b00; in_ready=1 the following cycle.
- Streaming: in_valid=1 and out_ready=1 every cycle for 8 instructions -> one output per cycle after the 1-cycle latency, same order, count stays 1.
- Flush while FIFO is full and in_valid=1 with instr=0x34A5000F -> next cycle: out_valid=0, in_ready=1; the ORI is never output.
- Assert rst_n=0 asynchronously mid-stream with 2 entries held -> out_valid=0 and out_instr=0 before the next clock edge.
- With IF_ID_STALL_CNT_EN defined: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; a flush leaves it at 5.
